// File: rtl/serializer_pkg.sv
// Shared types and constants for the serializer_piso block.
package serializer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;

  // Line level held on serial_out while no bit is valid (mark level).
  localparam logic IDLE_LVL_DEFAULT = 1'b1;

endpackage

// File: rtl/serializer_parity_gen.sv
// Even-parity generator: XOR reduction of one data word.
// Only instantiated when SERIALIZER_PARITY_EN is defined.
module parity_gen #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] data,
  output logic             parity
);

  // XOR of all bits: 1 when the word holds an odd number of ones.
  always_comb parity = ^data;

endmodule

// File: rtl/serializer_piso.sv
// Parallel-in/serial-out serializer with valid/ready input handshake.
// Words are accepted when din_valid & din_ready and shifted out one bit per
// clock, gapless when the next word is offered during the last bit.
// Optional build macro: SERIALIZER_PARITY_EN appends an even-parity bit
// after each word (one extra PARITY cycle).
module serializer_piso
  import serializer_pkg::*;
#(
  parameter int   WIDTH     = 8,
  parameter bit   MSB_FIRST = 1'b1,
  parameter logic IDLE_LVL  = IDLE_LVL_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             busy,
  output logic             done
);

  localparam int             CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  // Bit that leaves the line first for a freshly loaded word.
  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  // Move the next bit into the output position.
  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
  endfunction

  state_t             state, state_n;
  logic [WIDTH-1:0]   shreg, shreg_n;
  logic [CNT_W-1:0]   bit_cnt, bit_cnt_n;
  logic               out_n, valid_n, busy_n, done_n;
  logic               accept, load;

  assign accept = din_valid & din_ready;

`ifdef SERIALIZER_PARITY_EN
  logic par_word, par_q;

  parity_gen #(.WIDTH(WIDTH)) u_parity_gen (
    .data   (din),
    .parity (par_word)
  );

  // Capture the parity of each word as it is accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     par_q <= 1'b0;
    else if (load) par_q <= par_word;
  end
`endif

  // Ready depends only on state/bit_cnt so it never loops back on din_valid.
  always_comb begin
`ifdef SERIALIZER_PARITY_EN
    din_ready = (state == IDLE) || (state == PARITY);
`else
    din_ready = (state == IDLE) || ((state == SHIFT) && (bit_cnt == LAST));
`endif
  end

  // Next-state and next registered outputs; a load may happen from any state.
  always_comb begin
    state_n   = state;
    shreg_n   = shreg;
    bit_cnt_n = bit_cnt;
    out_n     = IDLE_LVL;
    valid_n   = 1'b0;
    busy_n    = 1'b0;
    done_n    = 1'b0;
    load      = 1'b0;

    case (state)
      IDLE: begin
        if (accept) load = 1'b1;
      end
      SHIFT: begin
        if (bit_cnt == LAST) begin
`ifdef SERIALIZER_PARITY_EN
          state_n = PARITY;
          out_n   = par_q;
          valid_n = 1'b1;
          busy_n  = 1'b1;
          done_n  = 1'b1;
`else
          if (accept) load = 1'b1;
          else        state_n = IDLE;
`endif
        end else begin
          shreg_n   = advance(shreg);
          bit_cnt_n = bit_cnt + CNT_W'(1);
          out_n     = first_bit(shreg_n);
          valid_n   = 1'b1;
          busy_n    = 1'b1;
`ifndef SERIALIZER_PARITY_EN
          done_n    = (bit_cnt_n == LAST);
`endif
        end
      end
`ifdef SERIALIZER_PARITY_EN
      PARITY: begin
        if (accept) load = 1'b1;
        else        state_n = IDLE;
      end
`endif
      default: state_n = IDLE;
    endcase

    // WIDTH >= 2, so the first bit of a word is never its last one.
    if (load) begin
      state_n   = SHIFT;
      shreg_n   = din;
      bit_cnt_n = '0;
      out_n     = first_bit(din);
      valid_n   = 1'b1;
      busy_n    = 1'b1;
      done_n    = 1'b0;
    end
  end

  // State, datapath and registered outputs; reset discards any partial word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      shreg        <= '0;
      bit_cnt      <= '0;
      serial_out   <= IDLE_LVL;
      serial_valid <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      state        <= state_n;
      shreg        <= shreg_n;
      bit_cnt      <= bit_cnt_n;
      serial_out   <= out_n;
      serial_valid <= valid_n;
      busy         <= busy_n;
      done         <= done_n;
    end
  end

endmodule

// File: tb/tb_serializer_piso.sv
// Directed bench for serializer_piso: one MSB-first and one LSB-first
// instance sharing clock and reset. Honors SERIALIZER_PARITY_EN.
module tb_serializer_piso;

  logic       clk;
  logic       reset;
  logic [7:0] din_a, din_b;
  logic       vld_a, vld_b;
  logic       rdy_a, rdy_b;
  logic       out_a, out_b;
  logic       sval_a, sval_b;
  logic       busy_a, busy_b;
  logic       done_a, done_b;

`ifdef SERIALIZER_PARITY_EN
  localparam int NB = 9;
`else
  localparam int NB = 8;
`endif

  serializer_piso #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LVL(1'b1)) dut_a (
    .clk(clk), .reset(reset), .din(din_a), .din_valid(vld_a), .din_ready(rdy_a),
    .serial_out(out_a), .serial_valid(sval_a), .busy(busy_a), .done(done_a)
  );

  serializer_piso #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LVL(1'b1)) dut_b (
    .clk(clk), .reset(reset), .din(din_b), .din_valid(vld_b), .din_ready(rdy_b),
    .serial_out(out_b), .serial_valid(sval_b), .busy(busy_b), .done(done_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  bit   sel_b;
  logic o_out, o_val, o_busy, o_done, o_rdy;

  // Observe whichever instance the current test drives.
  always_comb begin
    o_out  = sel_b ? out_b  : out_a;
    o_val  = sel_b ? sval_b : sval_a;
    o_busy = sel_b ? busy_b : busy_a;
    o_done = sel_b ? done_b : done_a;
    o_rdy  = sel_b ? rdy_b  : rdy_a;
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_out"},  o_out,  1);
    chk({tag, "_val"},  o_val,  0);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_done"}, o_done, 0);
    chk({tag, "_rdy"},  o_rdy,  1);
  endtask

  // Send one word from idle; seq is the expected line order, first bit in seq[7].
  task automatic send_word(input bit use_b, input logic [7:0] w,
                           input logic [7:0] seq, input logic par);
    sel_b = use_b;
    @(posedge clk); #1;
    if (use_b) begin din_b = w; vld_b = 1'b1; end
    else       begin din_a = w; vld_a = 1'b1; end
    @(negedge clk);
    chk("rdy_pre", o_rdy, 1);
    @(posedge clk); #1;
    vld_a = 1'b0; vld_b = 1'b0;
    din_a = ~w;   din_b = ~w;
    for (int i = 0; i < NB; i++) begin
      @(negedge clk);
      chk($sformatf("bit%0d", i),  o_out,  (i < 8) ? seq[7-i] : par);
      chk($sformatf("val%0d", i),  o_val,  1);
      chk($sformatf("busy%0d", i), o_busy, 1);
      chk($sformatf("done%0d", i), o_done, (i == NB-1) ? 1 : 0);
      chk($sformatf("rdy%0d", i),  o_rdy,  (i == NB-1) ? 1 : 0);
    end
    @(negedge clk);
    chk_idle("post");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [15:0] seq16;
    reset = 1'b1; sel_b = 1'b0;
    din_a = '0; din_b = '0; vld_a = 1'b0; vld_b = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_idle("rst");
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk_idle($sformatf("idle%0d", i));
    end

    // MSB first, 8'h36
    send_word(1'b0, 8'h36, 8'b00110110, 1'b0);
    // MSB first, 8'hA7 (parity 1)
    send_word(1'b0, 8'hA7, 8'b10100111, 1'b1);
    // LSB first, 8'h01 (parity 1)
    send_word(1'b1, 8'h01, 8'b10000000, 1'b1);

`ifndef SERIALIZER_PARITY_EN
    // Back-to-back 8'h36 then 8'hA5 with din_valid held
    sel_b = 1'b0;
    seq16 = 16'b0011011010100101;
    @(posedge clk); #1;
    din_a = 8'h36; vld_a = 1'b1;
    @(negedge clk);
    chk("b2b_rdy0", o_rdy, 1);
    @(posedge clk); #1;
    din_a = 8'hA5;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      chk($sformatf("b2b_bit%0d", c),  o_out, seq16[16-c]);
      chk($sformatf("b2b_val%0d", c),  o_val, 1);
      chk($sformatf("b2b_rdy%0d", c),  o_rdy, (c == 8 || c == 16) ? 1 : 0);
      chk($sformatf("b2b_done%0d", c), o_done, (c == 8 || c == 16) ? 1 : 0);
      if (c == 8) begin
        @(posedge clk); #1;
        vld_a = 1'b0; din_a = 8'h00;
      end
    end
    @(negedge clk);
    chk_idle("b2b_end");
`endif

    // Reset during the 4th bit of 8'hFF, then a clean 8'h0F
    sel_b = 1'b0;
    @(posedge clk); #1;
    din_a = 8'hFF; vld_a = 1'b1;
    @(posedge clk); #1;
    vld_a = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      chk($sformatf("ff_bit%0d", c), o_out, 1);
      chk($sformatf("ff_val%0d", c), o_val, 1);
    end
    reset = 1'b1;
    #1;
    chk_idle("mid_rst");
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk_idle("after_rst");
    send_word(1'b0, 8'h0F, 8'b00001111, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
